// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-client RAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } state_t;

  localparam logic MODE_WRITE = 1'b0;
  localparam logic MODE_READ  = 1'b1;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 3;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// client that was not granted last.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       win,
  output logic       any
);

  assign any = |req;
  assign win = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/ram_arbiter.sv
// Serialises two clients onto one single-port RAM, one access at a time,
// and routes read data back to the client that issued the read.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic            clock,
  input  logic            rst,
  input  logic [1:0]      req,
  input  logic [1:0]      mode,
  input  logic [2*AW-1:0] addr,
  input  logic [2*DW-1:0] wdata,
  output logic [1:0]      gnt,
  output logic [1:0]      rvalid,
  output logic [DW-1:0]   rdata,
  output logic [DW-1:0]   ram_din,
  output logic [AW-1:0]   ram_addr,
  output logic            ram_mode,
  input  logic [DW-1:0]   ram_dout
);

  state_t          state, state_nx;
  logic            last;
  logic            cli;
  logic            win, any;
  logic            cmd_mode;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_din;

  rr_pick2 u_pick (
    .req  (req),
    .last (last),
    .win  (win),
    .any  (any)
  );

  // State register.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state: one access per IDLE->ISSUE, reads take an extra RDATA cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any) state_nx = ISSUE;
      ISSUE:   state_nx = (cmd_mode == MODE_READ) ? RDATA : IDLE;
      RDATA:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Capture the winner's command; the pointer moves only when a grant is made.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      last     <= 1'b1;
      cli      <= 1'b0;
      cmd_mode <= MODE_READ;
      cmd_addr <= '0;
      cmd_din  <= '0;
    end else if (state == IDLE && any) begin
      last     <= win;
      cli      <= win;
      cmd_mode <= mode[win];
      cmd_addr <= win ? addr[2*AW-1:AW]  : addr[AW-1:0];
      cmd_din  <= win ? wdata[2*DW-1:DW] : wdata[DW-1:0];
    end
  end

  // Read return: register RAM output and flag the owning client.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      rvalid <= '0;
      if (state == RDATA) begin
        rdata       <= ram_dout;
        rvalid[cli] <= 1'b1;
      end
    end
  end

  // RAM port is driven only in ISSUE; otherwise park as a harmless read of 0.
  always_comb begin
    gnt      = '0;
    ram_mode = MODE_READ;
    ram_addr = '0;
    ram_din  = '0;
    if (state == ISSUE) begin
      gnt[cli] = 1'b1;
      ram_mode = cmd_mode;
      ram_addr = cmd_addr;
      ram_din  = cmd_din;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Integration bench: arbiter plus behavioural 8x8 single-port RAM, checked
// cycle by cycle against a transaction-level reference model.
module tb_ram_arbiter;

  typedef struct {
    logic       mode;
    logic [2:0] addr;
    logic [7:0] data;
  } op_t;

  logic       clock = 1'b0;
  logic       rst   = 1'b0;
  logic [1:0] req   = '0;
  logic [1:0] mode  = '0;
  logic [5:0] addr  = '0;
  logic [15:0] wdata = '0;
  logic [1:0] gnt, rvalid;
  logic [7:0] rdata, ram_din, ram_dout;
  logic [2:0] ram_addr;
  logic       ram_mode;

  logic [7:0] ram [8];

  ram_arbiter #(.DW(8), .AW(3)) dut (
    .clock    (clock),
    .rst      (rst),
    .req      (req),
    .mode     (mode),
    .addr     (addr),
    .wdata    (wdata),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .ram_din  (ram_din),
    .ram_addr (ram_addr),
    .ram_mode (ram_mode),
    .ram_dout (ram_dout)
  );

  always #5 clock = ~clock;

  initial begin
    for (int i = 0; i < 8; i++) ram[i] = 8'h00;
    ram_dout = 8'h00;
  end

  // Single-port RAM: write at end of the cycle, read data the next cycle.
  always @(posedge clock) begin
    if (ram_mode == 1'b0) ram[ram_addr] <= ram_din;
    else                  ram_dout <= ram[ram_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Client queues and reference model state.
  op_t q0[$];
  op_t q1[$];
  int         cyc     = 0;
  int         free_at = 0;
  int         gnt_cyc = -1;
  int         rv_cyc  = -1;
  bit         g_cli, rv_cli;
  op_t        g_op;
  logic [7:0] rv_data;
  logic [7:0] exp_rdata = 8'h00;
  bit         m_last = 1'b1;
  logic [7:0] mmem [8];

  initial for (int i = 0; i < 8; i++) mmem[i] = 8'h00;

  function automatic op_t mk(input bit m, input int a, input int d);
    op_t o;
    o.mode = m;
    o.addr = a[2:0];
    o.data = d[7:0];
    return o;
  endfunction

  task automatic drive_inputs();
    if (q0.size() != 0) begin
      req[0] = 1'b1; mode[0] = q0[0].mode; addr[2:0] = q0[0].addr; wdata[7:0] = q0[0].data;
    end else req[0] = 1'b0;
    if (q1.size() != 0) begin
      req[1] = 1'b1; mode[1] = q1[0].mode; addr[5:3] = q1[0].addr; wdata[15:8] = q1[0].data;
    end else req[1] = 1'b0;
  endtask

  task automatic step();
    logic [1:0] eg, er;
    bit w;
    @(posedge clock);
    #1;
    cyc++;
    eg = (cyc == gnt_cyc) ? (2'b01 << g_cli) : 2'b00;
    er = (cyc == rv_cyc)  ? (2'b01 << rv_cli) : 2'b00;
    if (cyc == rv_cyc) exp_rdata = rv_data;
    chk("gnt", gnt, eg);
    chk("rvalid", rvalid, er);
    chk("rdata", rdata, exp_rdata);
    if (eg != 2'b00) begin
      chk("ram_mode", ram_mode, g_op.mode);
      chk("ram_addr", ram_addr, g_op.addr);
      if (g_op.mode == 1'b0) chk("ram_din", ram_din, g_op.data);
      if (eg[0]) void'(q0.pop_front());
      if (eg[1]) void'(q1.pop_front());
    end else begin
      chk("idle_mode", ram_mode, 1'b1);
      chk("idle_addr", ram_addr, 3'd0);
      chk("idle_din", ram_din, 8'd0);
    end
    drive_inputs();
    if (rst && cyc >= free_at && req != 2'b00) begin
      w = (req == 2'b11) ? ~m_last : req[1];
      m_last  = w;
      g_cli   = w;
      g_op    = w ? q1[0] : q0[0];
      gnt_cyc = cyc + 1;
      if (g_op.mode == 1'b0) begin
        mmem[g_op.addr] = g_op.data;
        free_at = cyc + 2;
      end else begin
        rv_cyc  = cyc + 3;
        rv_cli  = w;
        rv_data = mmem[g_op.addr];
        free_at = cyc + 3;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    q0.delete();
    q1.delete();
    req = 2'b00;
    gnt_cyc = -1;
    rv_cyc = -1;
    exp_rdata = 8'h00;
    m_last = 1'b1;
    #1;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_rvalid", rvalid, 2'b00);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_mode", ram_mode, 1'b1);
    chk("rst_addr", ram_addr, 3'd0);
    chk("rst_din", ram_din, 8'd0);
    step();
    step();
    rst = 1'b1;
    free_at = 0;
  endtask

  task automatic drain();
    int k = 0;
    while ((q0.size() != 0 || q1.size() != 0 || cyc < free_at || cyc <= rv_cyc) && k < 2000) begin
      step();
      k++;
    end
    chk("drain_timeout", q0.size() + q1.size(), 0);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    do_reset();
    step();

    // Write then read back from one client.
    q0.push_back(mk(0, 5, 8'h2A));
    q0.push_back(mk(1, 5, 0));
    drain();
    chk("readback_2a", rdata, 8'h2A);

    // Reset while a read sits in its data cycle: dropped, no rvalid.
    q1.push_back(mk(1, 5, 0));
    begin
      int k = 0;
      while (!(rv_cyc > 0 && cyc == rv_cyc - 1) && k < 20) begin
        step();
        k++;
      end
      chk("reach_rdata", k < 20, 1'b1);
    end
    do_reset();
    repeat (5) step();

    // Simultaneous first requests after reset: client 0 wins the tie.
    q0.push_back(mk(0, 1, 8'h11));
    q1.push_back(mk(0, 2, 8'h22));
    q0.push_back(mk(1, 1, 0));
    q1.push_back(mk(1, 2, 0));
    drain();

    // Both streaming writes to every address, then read everything back.
    for (int i = 0; i < 8; i++) begin
      q0.push_back(mk(0, i, $urandom_range(0, 255)));
      q1.push_back(mk(0, i, $urandom_range(0, 255)));
    end
    drain();
    for (int i = 0; i < 8; i++) q0.push_back(mk(1, i, 0));
    drain();

    // Read and write to the same address contending.
    q0.push_back(mk(0, 7, 8'h5A));
    q1.push_back(mk(1, 7, 0));
    drain();
    q1.push_back(mk(1, 7, 0));
    drain();

    // Quiet period.
    repeat (20) step();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if (q0.size() < 3 && $urandom_range(0, 2) == 0)
        q0.push_back(mk($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255)));
      if (q1.size() < 3 && $urandom_range(0, 2) == 0)
        q1.push_back(mk($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255)));
      step();
    end
    drain();
    for (int i = 0; i < 8; i++) q1.push_back(mk(1, i, 0));
    drain();
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
